// File: rtl/aes_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_seq_pkg
// Shared definitions for the AES-128 decryption round sequencer:
//   - state_e    : FSM state encoding (IDLE, LOAD, KEY_START, KEY_WAIT, ROUND, DONE)
//   - OP_*       : op_sel codes driven to the round datapath
//   - AES_ROUNDS : default number of cipher rounds (AES-128)
// -----------------------------------------------------------------------------
package aes_seq_pkg;

  localparam int AES_ROUNDS = 10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_KEY_START = 3'd2,
    S_KEY_WAIT  = 3'd3,
    S_ROUND     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam logic [1:0] OP_ARK = 2'd0;  // AddRoundKey
  localparam logic [1:0] OP_ISR = 2'd1;  // InvShiftRows
  localparam logic [1:0] OP_ISB = 2'd2;  // InvSubBytes
  localparam logic [1:0] OP_IMC = 2'd3;  // InvMixColumns (one column per cycle)

endpackage

// File: rtl/aes_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_seq_ctrl_if
// Bundles the sequencer's request/response and datapath control signals.
//   master modport : requester/datapath side (drives io_ready, key_done, key_changed)
//   slave  modport : the sequencer (drives everything else)
// Signals:
//   io_ready    level, message and key valid in io_module
//   aes_ready   level, decrypted message valid
//   busy        high in every state except IDLE and DONE
//   load_msg    one-cycle pulse, datapath loads the ciphertext
//   key_start   one-cycle pulse to the key-expansion unit
//   key_done    key expansion complete (only looked at while waiting for it)
//   key_changed key differs from the last expanded key (key-cache builds only)
//   op_valid    state-register write enable for the current operation
//   op_sel      0 ARK, 1 ISR, 2 ISB, 3 IMC
//   rk_idx      round-key index for ARK
//   word_sel    column processed by IMC
//   dbg_state   current FSM state, for observation only
// Handshake: io_ready is a level request held by the requester for the whole
// run; aes_ready answers as a level and stays high until io_ready drops. Any
// drop of io_ready before DONE abandons the run. op_valid is a pure strobe
// with no back-pressure: the datapath must accept every operation issued.
// -----------------------------------------------------------------------------
interface aes_seq_ctrl_if;
  logic       io_ready;
  logic       aes_ready;
  logic       busy;
  logic       load_msg;
  logic       key_start;
  logic       key_done;
  logic       key_changed;
  logic       op_valid;
  logic [1:0] op_sel;
  logic [3:0] rk_idx;
  logic [1:0] word_sel;
  logic [2:0] dbg_state;

  modport master (
    output io_ready, key_done, key_changed,
    input  aes_ready, busy, load_msg, key_start, op_valid, op_sel, rk_idx,
           word_sel, dbg_state
  );

  modport slave (
    input  io_ready, key_done, key_changed,
    output aes_ready, busy, load_msg, key_start, op_valid, op_sel, rk_idx,
           word_sel, dbg_state
  );
endinterface

// File: rtl/aes_seq_counter.sv
// -----------------------------------------------------------------------------
// aes_seq_counter
// Position within the inverse-cipher operation schedule.
//   round counts down from NUM_ROUNDS to 0; step is the slot inside a round:
//   0 ISR, 1 ISB, 2 ARK, 3..6 IMC on columns 0..3.
//   The initial whitening ARK is represented as round = NUM_ROUNDS, step = 2,
//   and the final round ends at its ARK (round = 0, step = 2).
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear_i     return to the first operation of the schedule
//   advance_i   move to the next operation
//   step_o      current in-round step (0..6)
//   round_o     current round (counting down)
//   word_o      IMC column, meaningful only for steps 3..6
//   last_o      current operation is the final ARK
// -----------------------------------------------------------------------------
module aes_seq_counter
  import aes_seq_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_ROUNDS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [2:0] step_o,
  output logic [3:0] round_o,
  output logic [1:0] word_o,
  output logic       last_o
);

  localparam logic [3:0] ROUND_INIT = 4'(NUM_ROUNDS);
  localparam logic [2:0] STEP_ARK   = 3'd2;
  localparam logic [2:0] STEP_LAST  = 3'd6;

  logic [2:0] step_q, step_d;
  logic [3:0] round_q, round_d;

  always_comb begin
    step_d  = step_q;
    round_d = round_q;
    if (clear_i) begin
      step_d  = STEP_ARK;
      round_d = ROUND_INIT;
    end else if (advance_i && !last_o) begin
      // The whitening ARK is a one-operation round; every other round ends
      // after its fourth IMC column.
      if (step_q == STEP_LAST || (step_q == STEP_ARK && round_q == ROUND_INIT)) begin
        step_d  = 3'd0;
        round_d = round_q - 4'd1;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= STEP_ARK;
      round_q <= ROUND_INIT;
    end else begin
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

  assign step_o  = step_q;
  assign round_o = round_q;
  assign word_o  = 2'(step_q - 3'd3);
  assign last_o  = (round_q == 4'd0) && (step_q == STEP_ARK);

endmodule

// File: rtl/aes_seq_ctrl.sv
// -----------------------------------------------------------------------------
// aes_seq_ctrl
// Sequencer for the shared AES-128 decryption round datapath. On a request it
// loads the ciphertext, starts key expansion, waits for it, then issues the
// inverse-cipher schedule one operation per clock and holds aes_ready until
// the request is withdrawn.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    aes_seq_ctrl_if.slave (request, key-expansion and datapath control)
// Optional feature, macro AES_SEQ_KEY_CACHE_EN: remember that the current key
// is already expanded and skip KEY_START/KEY_WAIT while key_changed is low.
// All outputs are decoded from registered state, so an asynchronous reset
// clears them immediately.
// -----------------------------------------------------------------------------
module aes_seq_ctrl
  import aes_seq_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_ROUNDS
) (
  input logic           clk,
  input logic           reset,
  aes_seq_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'(S_IDLE);
  localparam logic [2:0] LOAD      = 3'(S_LOAD);
  localparam logic [2:0] KEY_START = 3'(S_KEY_START);
  localparam logic [2:0] KEY_WAIT  = 3'(S_KEY_WAIT);
  localparam logic [2:0] ROUND     = 3'(S_ROUND);
  localparam logic [2:0] DONE      = 3'(S_DONE);

  logic [2:0] state_q, state_d;
  logic [2:0] step;
  logic [3:0] round;
  logic [1:0] word;
  logic       last_op;
  logic       skip_key;
  logic       in_round;

  assign in_round = (state_q == ROUND);

  // Holding the counter cleared outside ROUND guarantees it starts at the
  // whitening ARK on every entry, including after an abort.
  aes_seq_counter #(.NUM_ROUNDS(NUM_ROUNDS)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!in_round),
    .advance_i (in_round),
    .step_o    (step),
    .round_o   (round),
    .word_o    (word),
    .last_o    (last_op)
  );

`ifdef AES_SEQ_KEY_CACHE_EN
  logic cache_q, cache_d;

  always_comb begin
    cache_d = cache_q;
    // An abort while expansion is pending leaves the expanded key unknown.
    if ((state_q == KEY_START || state_q == KEY_WAIT) && !bus.io_ready) begin
      cache_d = 1'b0;
    end else if (state_q == KEY_WAIT && bus.key_done) begin
      cache_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cache_q <= 1'b0;
    else       cache_q <= cache_d;
  end

  assign skip_key = cache_q && !bus.key_changed;
`else
  logic unused_key_changed;
  assign unused_key_changed = bus.key_changed;
  assign skip_key = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.io_ready) state_d = LOAD;
      LOAD: begin
        if (!bus.io_ready) state_d = IDLE;
        else if (skip_key) state_d = ROUND;
        else               state_d = KEY_START;
      end
      KEY_START: state_d = bus.io_ready ? KEY_WAIT : IDLE;
      KEY_WAIT: begin
        if (!bus.io_ready)     state_d = IDLE;
        else if (bus.key_done) state_d = ROUND;
      end
      ROUND: begin
        if (!bus.io_ready) state_d = IDLE;
        else if (last_op)  state_d = DONE;
      end
      DONE:      if (!bus.io_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operation decode; all fields stay 0 while no operation is issued.
  always_comb begin
    bus.op_sel   = OP_ARK;
    bus.rk_idx   = 4'd0;
    bus.word_sel = 2'd0;
    if (in_round) begin
      case (step)
        3'd0:    bus.op_sel = OP_ISR;
        3'd1:    bus.op_sel = OP_ISB;
        3'd2: begin
          bus.op_sel = OP_ARK;
          bus.rk_idx = round;
        end
        default: begin
          bus.op_sel   = OP_IMC;
          bus.word_sel = word;
        end
      endcase
    end
  end

  assign bus.op_valid  = in_round;
  assign bus.load_msg  = (state_q == LOAD);
  assign bus.key_start = (state_q == KEY_START);
  assign bus.aes_ready = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.dbg_state = state_q;

endmodule
